// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and helpers for the clk_div_gen clock-enable
// generator.
//   DEF_DIV_W    default divisor width
//   DEF_LOCK_CYC default settle cycles before lock asserts
//   DEF_DIV_2CH  default reset divisors for two channels (ch0 = /2, ch1 = /4)
//   half_up(n)   ceil(n/2); the number of high cycles of an n-cycle phase flag
package clk_div_pkg;

    localparam int unsigned DEF_DIV_W    = 8;
    localparam int unsigned DEF_LOCK_CYC = 16;
    localparam logic [15:0] DEF_DIV_2CH  = {8'd4, 8'd2};

    function automatic int unsigned half_up(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel of clk_div_gen.
//   clkin   system clock (rising edge)
//   rst_n   asynchronous active-low reset
//   wr_en   load wr_div into the pending divisor
//   wr_div  new divisor (0 = channel disabled)
//   sync    realign phase to 0 and apply any pending divisor now
//   apply   a pending divisor is being applied on this edge
//   ce      one-cycle enable strobe per period
//   clk     square-wave phase flag
//   pend    a written divisor is waiting for the next period boundary
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      DIV_W   = DEF_DIV_W,
    parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(2)
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             sync,
    output logic             apply,
    output logic             ce,
    output logic             clk,
    output logic             pend
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_div_pend;
    logic [DIV_W-1:0] r_ph;
    logic             r_pend;
    logic             r_ce;
    logic             r_clk;

    logic             w_enabled;
    logic             w_wrap;
    logic             w_boundary;
    logic             w_apply;
    logic [DIV_W-1:0] w_half;

    assign w_enabled  = (r_div_act != '0);
    assign w_wrap     = (r_ph == r_div_act - ONE);
    // Divisors 0 and 1 have no multi-cycle period, so every edge is a boundary.
    assign w_boundary = (r_div_act <= ONE) || w_wrap;
    assign w_apply    = r_pend && (sync || w_boundary);
    assign w_half     = DIV_W'(half_up(32'(r_div_act)));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_div_act  <= RST_DIV;
            r_div_pend <= '0;
            r_ph       <= '0;
            r_pend     <= 1'b0;
            r_ce       <= 1'b0;
            r_clk      <= 1'b0;
        end else begin
            // Outputs come from the current phase, so the old period always
            // finishes on the apply edge and the new cadence starts one edge later.
            if (w_enabled) begin
                r_ce  <= (r_ph == '0);
                r_clk <= (r_ph < w_half);
            end else begin
                r_ce  <= 1'b0;
                r_clk <= 1'b0;
            end

            if (w_apply) begin
                r_div_act <= r_div_pend;
                r_ph      <= '0;
            end else if (sync || !w_enabled || w_wrap) begin
                r_ph <= '0;
            end else begin
                r_ph <= r_ph + ONE;
            end

            // A write landing on a boundary edge only becomes pending; the
            // apply above uses the previous pending flag.
            if (wr_en) begin
                r_div_pend <= wr_div;
                r_pend     <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign apply = w_apply;
    assign ce    = r_ce;
    assign clk   = r_clk;
    assign pend  = r_pend;

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable multi-channel clock-enable generator.
//   clkin      system clock (rising edge)
//   rst_n      asynchronous active-low reset
//   cfg_valid  divisor write request
//   cfg_ready  addressed channel has no pending divisor
//   cfg_ch     target channel (values >= NCH are accepted and dropped)
//   cfg_div    new divisor (0 = channel disabled)
//   sync_i     single-cycle pulse realigning all channels to phase 0
//   ce_o       per-channel one-cycle enable strobe
//   clk_o      per-channel square-wave phase flag
//   lock_o     outputs stable for at least LOCK_CYC cycles
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned              NCH      = 2,
    parameter int unsigned              DIV_W    = DEF_DIV_W,
    parameter logic [NCH*DIV_W-1:0]     DEF_DIV  = DEF_DIV_2CH,
    parameter int unsigned              LOCK_CYC = DEF_LOCK_CYC,
    localparam int unsigned             CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             sync_i,
    output logic [NCH-1:0]   ce_o,
    output logic [NCH-1:0]   clk_o,
    output logic             lock_o
);

    localparam int unsigned    LCW      = $clog2(LOCK_CYC + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYC);

    logic [NCH-1:0]         w_wr_en;
    logic [NCH-1:0]         w_apply;
    logic [NCH-1:0]         w_pend;
    logic [(1<<CH_W)-1:0]   w_pend_ext;
    logic                   w_accept;
    logic                   w_clr;
    logic [LCW-1:0]         w_lock_nxt;

    logic [LCW-1:0]         r_lock_cnt;
    logic                   r_lock_hold;
    logic                   r_lock;

    // Unpopulated channel numbers read as never pending, so they always accept.
    always_comb begin
        w_pend_ext          = '0;
        w_pend_ext[NCH-1:0] = w_pend;
    end

    assign cfg_ready = !w_pend_ext[cfg_ch];
    assign w_accept  = cfg_valid && cfg_ready;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign w_wr_en[gi] = w_accept && (cfg_ch == CH_W'(gi));

        clk_div_chan #(
            .DIV_W   (DIV_W),
            .RST_DIV (DEF_DIV[gi*DIV_W +: DIV_W])
        ) u_chan (
            .clkin  (clkin),
            .rst_n  (rst_n),
            .wr_en  (w_wr_en[gi]),
            .wr_div (cfg_div),
            .sync   (sync_i),
            .apply  (w_apply[gi]),
            .ce     (ce_o[gi]),
            .clk    (clk_o[gi]),
            .pend   (w_pend[gi])
        );
    end

    assign w_clr = (|w_apply) || sync_i;

    // After an apply/sync the counter sits at zero for two edges, so lock
    // returns LOCK_CYC+1 edges after the disturbing edge, while from reset it
    // returns on the LOCK_CYC-th edge.
    always_comb begin
        w_lock_nxt = r_lock_cnt;
        if (w_clr) begin
            w_lock_nxt = '0;
        end else if (!r_lock_hold && (r_lock_cnt != LOCK_MAX)) begin
            w_lock_nxt = r_lock_cnt + LCW'(1);
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt  <= '0;
            r_lock_hold <= 1'b0;
            r_lock      <= 1'b0;
        end else begin
            r_lock_cnt  <= w_lock_nxt;
            r_lock_hold <= w_clr;
            r_lock      <= (w_lock_nxt == LOCK_MAX);
        end
    end

    assign lock_o = r_lock;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed, table-driven self-checking bench for clk_div_gen
// with two channels, reset divisors {4, 2} and LOCK_CYC = 16.
module tb_clk_div_gen;

    logic       clkin = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       sync_i;
    logic [1:0] ce_o;
    logic [1:0] clk_o;
    logic       lock_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       cfg_valid;
        logic       sync;
        logic [1:0] ce;
        logic [1:0] clk;
        logic       lock;
        logic       ready;
    } vec_t;

    vec_t rst_tab[8];
    vec_t sync_tab[6];

    clk_div_gen #(
        .NCH      (2),
        .DIV_W    (8),
        .DEF_DIV  ({8'd4, 8'd2}),
        .LOCK_CYC (16)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .sync_i    (sync_i),
        .ce_o      (ce_o),
        .clk_o     (clk_o),
        .lock_o    (lock_o)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Default cadence from reset release: ch0 /2, ch1 /4.
    task automatic run_rst_tab(input string tag);
        for (int i = 0; i < 8; i++) begin
            cfg_valid = rst_tab[i].cfg_valid;
            sync_i    = rst_tab[i].sync;
            tick();
            chk($sformatf("%s[%0d].ce", tag, i), 32'(ce_o), 32'(rst_tab[i].ce));
            chk($sformatf("%s[%0d].clk", tag, i), 32'(clk_o), 32'(rst_tab[i].clk));
            chk($sformatf("%s[%0d].lock", tag, i), 32'(lock_o), 32'(rst_tab[i].lock));
            chk($sformatf("%s[%0d].ready", tag, i), 32'(cfg_ready), 32'(rst_tab[i].ready));
        end
    endtask

    initial begin
        //             valid  sync  ce     clk    lock  ready
        rst_tab[0] = '{1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 1'b1};
        rst_tab[1] = '{1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1};
        rst_tab[2] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        rst_tab[3] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
        rst_tab[4] = '{1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 1'b1};
        rst_tab[5] = '{1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1};
        rst_tab[6] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        rst_tab[7] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
        // After sync: ch0 restarts at /4, ch1 at /5, both from phase 0.
        sync_tab[0] = '{1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 1'b1};
        sync_tab[1] = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b1};
        sync_tab[2] = '{1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1};
        sync_tab[3] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
        sync_tab[4] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        sync_tab[5] = '{1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b1};

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd0;
        sync_i    = 1'b0;
        #12;
        chk("reset.ce", 32'(ce_o), 32'd0);
        chk("reset.clk", 32'(clk_o), 32'd0);
        chk("reset.lock", 32'(lock_o), 32'd0);
        chk("reset.ready", 32'(cfg_ready), 32'd1);
        @(posedge clkin);
        #1;
        rst_n = 1'b1;

        // Edges 1..8: default cadence.
        run_rst_tab("rst");
        // Edges 9..16: lock rises exactly on edge 16.
        for (int e = 9; e <= 16; e++) begin
            tick();
            chk($sformatf("lock_edge%0d", e), 32'(lock_o), 32'(e == 16));
        end

        // Write ch0 = 3 while ch0 is at phase 0 of a /2 period.
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd3;
        tick();                                       // edge 17: accepted
        chk("wr3.ready_pend", 32'(cfg_ready), 32'd0);
        chk("wr3.ce0_e17", 32'(ce_o[0]), 32'd1);
        chk("wr3.lock_e17", 32'(lock_o), 32'd1);
        cfg_valid = 1'b0;
        tick();                                       // edge 18: old /2 period ends, apply
        chk("wr3.ce0_e18", 32'(ce_o[0]), 32'd0);
        chk("wr3.lock_e18", 32'(lock_o), 32'd0);
        chk("wr3.ready_applied", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin           // edges 19..34
            tick();
            chk($sformatf("div3[%0d].ce0", i), 32'(ce_o[0]), 32'((i % 3) == 0));
            chk($sformatf("div3[%0d].clk0", i), 32'(clk_o[0]), 32'((i % 3) != 2));
            chk($sformatf("div3[%0d].lock", i), 32'(lock_o), 32'd0);
        end
        tick();                                       // edge 35
        chk("wr3.lock_back", 32'(lock_o), 32'd1);
        tick();                                       // edge 36: ch1 phase now 0

        // Two writes to ch1; the second is held while the first is pending.
        cfg_valid = 1'b1;
        cfg_ch    = 1'b1;
        cfg_div   = 8'd3;
        tick();                                       // edge 37: first accepted
        chk("ch1.ready_e37", 32'(cfg_ready), 32'd0);
        cfg_div = 8'd5;
        tick();
        chk("ch1.ready_e38", 32'(cfg_ready), 32'd0);
        tick();
        chk("ch1.ready_e39", 32'(cfg_ready), 32'd0);
        tick();                                       // edge 40: /4 boundary applies 3
        chk("ch1.ready_e40", 32'(cfg_ready), 32'd1);
        tick();                                       // edge 41: held write accepted
        chk("ch1.ce_div3_start", 32'(ce_o[1]), 32'd1);
        chk("ch1.ready_e41", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        tick();
        chk("ch1.ce_e42", 32'(ce_o[1]), 32'd0);
        tick();                                       // edge 43: /3 boundary applies 5
        chk("ch1.ce_e43", 32'(ce_o[1]), 32'd0);
        chk("ch1.ready_e43", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin            // edges 44..49
            tick();
            chk($sformatf("div5[%0d].ce1", i), 32'(ce_o[1]), 32'((i % 5) == 0));
        end

        // Pending ch0 = 4, then sync while ch1 is at phase 2.
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd4;
        tick();                                       // edge 50: accepted, pending
        chk("sync.ready_pend", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        sync_i    = 1'b1;
        tick();                                       // edge 51: sync, ch0 applies
        chk("sync.ce_e51", 32'(ce_o), 32'd0);
        chk("sync.ready_applied", 32'(cfg_ready), 32'd1);
        chk("sync.lock", 32'(lock_o), 32'd0);
        sync_i = 1'b0;
        for (int i = 0; i < 6; i++) begin            // edges 52..57
            cfg_valid = sync_tab[i].cfg_valid;
            sync_i    = sync_tab[i].sync;
            tick();
            chk($sformatf("sync[%0d].ce", i), 32'(ce_o), 32'(sync_tab[i].ce));
            chk($sformatf("sync[%0d].clk", i), 32'(clk_o), 32'(sync_tab[i].clk));
            chk($sformatf("sync[%0d].lock", i), 32'(lock_o), 32'(sync_tab[i].lock));
        end
        for (int i = 0; i < 3; i++) tick();           // edges 58..60

        // ch1 = 0 written on a ch1 boundary edge: it waits for the next one.
        cfg_valid = 1'b1;
        cfg_ch    = 1'b1;
        cfg_div   = 8'd0;
        tick();                                       // edge 61: boundary + write
        chk("off.ready_pend", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        tick();                                       // edge 62: still /5
        chk("off.ce1_still_running", 32'(ce_o[1]), 32'd1);
        for (int i = 0; i < 3; i++) tick();           // edges 63..65
        chk("off.ready_e65", 32'(cfg_ready), 32'd0);
        tick();                                       // edge 66: applies 0
        chk("off.ready_applied", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin            // edges 67..68
            tick();
            chk($sformatf("off[%0d].ce1", i), 32'(ce_o[1]), 32'd0);
            chk($sformatf("off[%0d].clk1", i), 32'(clk_o[1]), 32'd0);
        end
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        tick();                                       // edge 69: accepted
        chk("div1.ready_pend", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        tick();                                       // edge 70: applied after 1 cycle
        chk("div1.ready_applied", 32'(cfg_ready), 32'd1);
        chk("div1.ce1_e70", 32'(ce_o[1]), 32'd0);
        for (int i = 0; i < 4; i++) begin            // edges 71..74
            tick();
            chk($sformatf("div1[%0d].ce1", i), 32'(ce_o[1]), 32'd1);
            chk($sformatf("div1[%0d].clk1", i), 32'(clk_o[1]), 32'd1);
        end

        // Reset with a write pending on ch0.
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd7;
        tick();
        chk("rst2.ready_pend", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2.ce_async", 32'(ce_o), 32'd0);
        chk("rst2.clk_async", 32'(clk_o), 32'd0);
        chk("rst2.lock_async", 32'(lock_o), 32'd0);
        chk("rst2.ready_cleared", 32'(cfg_ready), 32'd1);
        tick();
        chk("rst2.ce_held", 32'(ce_o), 32'd0);
        rst_n = 1'b1;
        run_rst_tab("rst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
